jit_emit_seq: RTL and testbench
===============================

JIT_EMIT_SEQ -- requirements
Module: jit_emit_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, code-buffer word-address width.
REQ-002 SHALL have parameter LEN_W, default 3, request word-count width (maximum 7 words).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  template request present.
REQ-006 req_ready  out  1  request accepted when high together with req_valid.
REQ-007 req_base  in  7  first template-ROM index.
REQ-008 req_len  in  LEN_W  number of words to emit (0 allowed).
REQ-009 req_cond  in  4  ARM condition code to substitute.
REQ-010 req_cond_en  in  1  enables condition substitution for this request.
REQ-011 rom_addr  out  7  template-ROM index; the ROM is combinational and external.
REQ-012 rom_data  in  32  ROM word for rom_addr, valid in the same cycle; 32'hFFFFFFFF means unmapped.
REQ-013 out_valid / out_ready  out / in  1 / 1  word-stream handshake to the code buffer.
REQ-014 out_data  out  32  emitted ARM instruction word.
REQ-015 out_addr  out  ADDR_W  code-buffer word address for out_data.
REQ-016 out_last  out  1  marks the final word of the current request.
REQ-017 flush  in  1  aborts any sequence and clears the code pointer.
REQ-018 busy / done / err  out  1 each  sequence active / one-cycle completion pulse / sticky unmapped-word flag.

Function
REQ-019 SHALL implement the states IDLE and EMIT.
REQ-020 In IDLE, req_ready SHALL be 1 unless flush=1.
- On accept with req_len>0: capture base, len and cond into registers; go to EMIT next cycle.
- On accept with req_len=0: stay in IDLE and pulse done on the next cycle; no words are emitted.
REQ-021 In EMIT, state SHALL be as follows.
- Outputs: out_valid=1, busy=1, req_ready=0.
- Addressing: rom_addr = base+idx (mod 128); out_data is derived combinationally from rom_data.
REQ-022 The first out_valid SHALL appear 1 cycle after accept; throughput SHALL be 1 word per cycle when out_ready=1.
REQ-023 While out_ready=0, out_data, out_addr and out_last SHALL hold stable.
REQ-024 On each out_valid&&out_ready handshake, idx and the code pointer SHALL increment; the code pointer wraps mod 2^ADDR_W.
REQ-025 out_last SHALL equal (idx==len-1); its handshake returns the block to IDLE and pulses done for exactly 1 cycle in the following cycle.
REQ-026 If rom_data==32'hFFFFFFFF in EMIT, the block SHALL take the following actions.
- Set err, which stays set until rst or flush.
- Suppress out_valid in that cycle.
- Return to IDLE with no done pulse.
REQ-027 flush SHALL override everything in any state.
- Next state is IDLE, code pointer=0, err=0, idx=0.
- No done pulse; req_ready=0 during the flush cycle.
- A request coincident with flush is not accepted.
REQ-028 out_addr SHALL equal the code-pointer register value.

Reset
REQ-029 On rst, the registers SHALL take these values.
- State=IDLE, idx=0, code pointer=0.
- out_valid=0, done=0, err=0, busy=0; rom_addr=0.
- req_ready=1 once rst is deasserted.
REQ-030 Asserting rst mid-sequence SHALL abort immediately with no done pulse.

Configuration
REQ-031 Macro JIT_EMIT_COND_PATCH_EN, when defined, SHALL enable condition patching.
- Patch rule: when req_cond_en=1 and rom_data[31:28]==4'hE, out_data = {cond, rom_data[27:0]}.
- All other words pass unchanged.
REQ-032 Without JIT_EMIT_COND_PATCH_EN, the block SHALL behave as follows.
- out_data=rom_data always.
- req_cond and req_cond_en are ignored and not registered.

Structure
REQ-033 A shared package jit_emit_pkg SHALL hold the following.
- The state enum.
- ROM_AW=7 and WORD_W=32.
- ROM_UNMAPPED=32'hFFFFFFFF.
- COND_AL=4'hE.
REQ-034 Condition substitution SHALL live in the combinational sub-module jit_cond_patch; all sequencing stays in jit_emit_seq.

Verification
REQ-035 The bench SHALL cover a basic emit.
- Stimulus: base=0x03, len=2, out_ready=1 from reset.
- Response: E8BD0003@0, then E92D0003@1 with out_last=1; done pulses 1 cycle later.
REQ-036 The bench SHALL cover backpressure.
- Stimulus: base=0x0B, len=3, with out_ready=0 for 4 cycles on the second word.
- Response: ED2D0A01 held stable at addr 1; total 3 words at addresses 0..2; no duplicates.
REQ-037 The bench SHALL cover condition patching with the macro defined.
- Stimulus 1: base=0x01, len=1, cond_en=1, cond=0x0; response 049D0004.
- Stimulus 2: base=0x20 (word 00400000); response passes unchanged.
REQ-038 The bench SHALL cover unmapped and zero-length requests.
- Stimulus: base=0x43, len=1; response: err=1, no out_valid, no done, back to IDLE.
- Stimulus: len=0; response: done pulse and code pointer unchanged.
REQ-039 The bench SHALL cover flush and rst mid-sequence.
- Stimulus: flush asserted on the 2nd word of a len=5 request, with req_valid also high.
- Response: IDLE, out_addr=0, request not accepted.
- Stimulus: rst mid-sequence; response: all outputs at reset values.
REQ-040 The bench SHALL cover code-pointer wrap.
- Stimulus: 1025 single-word requests (ADDR_W=10).
- Response: the 1025th word lands at out_addr 0.

Source files
------------

// File: rtl/jit_emit_seq_pkg.sv
// Shared types and constants for the JIT template-emit sequencer.
package jit_emit_pkg;

  localparam int ROM_AW = 7;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ROM_UNMAPPED = 32'hFFFF_FFFF;
  localparam logic [3:0]        COND_AL      = 4'hE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // A template-ROM hole reads back as all ones.
  function automatic logic is_unmapped(input logic [WORD_W-1:0] word);
    return word == ROM_UNMAPPED;
  endfunction

endpackage

// File: rtl/jit_emit_seq_if.sv
// Request and word-stream handshake bundle for jit_emit_seq.
// master = requester / code buffer side, slave = the sequencer.
interface jit_emit_seq_if
  import jit_emit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [ROM_AW-1:0] req_base;
  logic [LEN_W-1:0]  req_len;
  logic [3:0]        req_cond;
  logic              req_cond_en;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output req_valid, req_base, req_len, req_cond, req_cond_en, out_ready,
    input  req_ready, out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  req_valid, req_base, req_len, req_cond, req_cond_en, out_ready,
    output req_ready, out_valid, out_data, out_addr, out_last
  );

endinterface

// File: rtl/jit_emit_seq_cond_patch.sv
// Combinational ARM condition-code substitution: an always-executed
// (AL) instruction takes the requested condition; everything else passes.
module jit_cond_patch
  import jit_emit_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [3:0]        cond_i,
  input  logic              cond_en_i,
  output logic [WORD_W-1:0] word_o
);

  // Replace the condition field only on AL words when enabled.
  always_comb begin
    word_o = word_i;
    if (cond_en_i && (word_i[31:28] == COND_AL)) begin
      word_o = {cond_i, word_i[27:0]};
    end
  end

endmodule

// File: rtl/jit_emit_seq.sv
// Template-emit sequencer: copies req_len words from a combinational
// template ROM into the code buffer, one word per accepted handshake.
// Optional feature macro: JIT_EMIT_COND_PATCH_EN (condition-code patching).
module jit_emit_seq
  import jit_emit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 3
)(
  input  logic               clk,
  input  logic               rst,
  jit_emit_seq_if.slave      bus,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [WORD_W-1:0]  rom_data,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                emit;
  logic                unmapped;
  logic                at_last;
  logic                start;
  logic [3:0]          patch_cond;
  logic                patch_en;

  assign emit     = (state_q == ST_EMIT);
  assign unmapped = is_unmapped(rom_data);
  assign at_last  = (idx_q == (len_q - LEN_W'(1)));
  assign start    = !emit && !flush && bus.req_valid && (bus.req_len != '0);

  // Handshake, ROM address and status outputs decoded from current state.
  always_comb begin
    rom_addr      = emit ? (base_q + ROM_AW'(idx_q)) : '0;
    bus.req_ready = !emit && !flush;
    bus.out_valid = emit && !unmapped && !flush;
    bus.out_last  = emit && at_last;
    bus.out_addr  = ptr_q;
    busy          = emit;
    done          = done_q;
    err           = err_q;
  end

`ifdef JIT_EMIT_COND_PATCH_EN
  logic [3:0] cond_q;
  logic       cond_en_q;

  // Condition captured with the request so it holds for the whole sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q    <= COND_AL;
      cond_en_q <= 1'b0;
    end else if (start) begin
      cond_q    <= bus.req_cond;
      cond_en_q <= bus.req_cond_en;
    end
  end

  assign patch_cond = cond_q;
  assign patch_en   = cond_en_q;
`else
  logic unused_cond;
  assign unused_cond = ^{bus.req_cond, bus.req_cond_en};
  assign patch_cond  = COND_AL;
  assign patch_en    = 1'b0;
`endif

  jit_cond_patch u_cond_patch (
    .word_i    (rom_data),
    .cond_i    (patch_cond),
    .cond_en_i (patch_en),
    .word_o    (bus.out_data)
  );

  // Next-state logic: flush dominates, then request accept / word emission.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_len != '0) begin
              base_d  = bus.req_base;
              len_d   = bus.req_len;
              idx_d   = '0;
              state_d = ST_EMIT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (unmapped) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else if (bus.out_ready) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (at_last) begin
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_jit_emit_seq.sv
// Self-checking bench for jit_emit_seq: a queue-based stream model plus
// hand-computed literal expectations for the directed scenarios.
module tb_jit_emit_seq;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 3;

  typedef struct {
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [6:0]        rom_addr;
  logic [31:0]       rom_data;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int hs_cnt = 0;
  logic exp_err = 1'b0;
  logic [ADDR_W-1:0] mptr = '0;
  exp_t exp_q[$];

  jit_emit_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  jit_emit_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Template ROM contents used by the scenarios.
  function automatic logic [31:0] rom_word(input logic [6:0] a);
    case (a)
      7'h01: return 32'hE49D0004;
      7'h03: return 32'hE8BD0003;
      7'h04: return 32'hE92D0003;
      7'h0B: return 32'hE52DE004;
      7'h0C: return 32'hED2D0A01;
      7'h0D: return 32'hE3A00000;
      7'h20: return 32'h00400000;
      7'h43: return 32'hFFFFFFFF;
      default: return 32'hE1A00000 + 32'(a);
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic [3:0] c,
                                             input logic en);
`ifdef JIT_EMIT_COND_PATCH_EN
    if (en && w[31:28] == 4'hE) return {c, w[27:0]};
`endif
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of one request: the words it must produce, or the error it must raise.
  task automatic push_req(input logic [6:0] base, input int len, input logic [3:0] c,
                          input logic en);
    logic stop;
    stop = 1'b0;
    if (len == 0) exp_done++;
    for (int i = 0; i < len; i++) begin
      logic [6:0]  a;
      logic [31:0] w;
      exp_t e;
      if (!stop) begin
        a = base + 7'(i);
        w = rom_word(a);
        if (w == 32'hFFFFFFFF) begin
          exp_err = 1'b1;
          stop = 1'b1;
        end else begin
          e.data = model_word(w, c, en);
          e.addr = mptr;
          e.last = (i == len - 1);
          exp_q.push_back(e);
          mptr = mptr + 1'b1;
        end
      end
    end
  endtask

  // Stream compare: every presented word must match the model's next entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("stream_extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        check("stream_data", bus.out_data, exp_q[0].data);
        check("stream_addr", 32'(bus.out_addr), 32'(exp_q[0].addr));
        check("stream_last", 32'(bus.out_last), 32'(exp_q[0].last));
        if (bus.out_ready) begin
          if (exp_q[0].last) exp_done++;
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [6:0] base, input int len, input logic [3:0] c,
                          input logic en);
    int n;
    bus.req_valid   = 1'b1;
    bus.req_base    = base;
    bus.req_len     = LEN_W'(len);
    bus.req_cond    = c;
    bus.req_cond_en = en;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    push_req(base, len, c, en);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'(exp_q.size()) + 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    mptr = '0;
    exp_err = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int hs0;
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_base = '0;
    bus.req_len = '0;
    bus.req_cond = '0;
    bus.req_cond_en = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset values.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();

    // Basic emit: base 0x03, len 2.
    send_req(7'h03, 2, 4'h0, 1'b0);
    check("basic_valid_lat1", 32'(bus.out_valid), 32'd1);
    check("basic_w0_data", bus.out_data, 32'hE8BD0003);
    check("basic_w0_addr", 32'(bus.out_addr), 32'd0);
    check("basic_w0_last", 32'(bus.out_last), 32'd0);
    check("basic_req_ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    check("basic_w1_data", bus.out_data, 32'hE92D0003);
    check("basic_w1_addr", 32'(bus.out_addr), 32'd1);
    check("basic_w1_last", 32'(bus.out_last), 32'd1);
    tick();
    check("basic_done_pulse", 32'(done), 32'd1);
    check("basic_idle", 32'(busy), 32'd0);
    tick();
    check("basic_done_clear", 32'(done), 32'd0);
    check("basic_done_count", 32'(done_cnt), 32'(exp_done));

    // Backpressure: base 0x0B, len 3, ready low for 4 cycles on word 2.
    do_flush();
    hs0 = hs_cnt;
    send_req(7'h0B, 3, 4'h0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_hold_data", bus.out_data, 32'hED2D0A01);
      check("bp_hold_addr", 32'(bus.out_addr), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle(20);
    check("bp_word_count", 32'(hs_cnt - hs0), 32'd3);
    check("bp_done_count", 32'(done_cnt), 32'(exp_done));

    // Condition patching.
    send_req(7'h01, 1, 4'h0, 1'b1);
`ifdef JIT_EMIT_COND_PATCH_EN
    check("patch_al_word", bus.out_data, 32'h049D0004);
`else
    check("patch_al_word", bus.out_data, 32'hE49D0004);
`endif
    wait_idle(20);
    send_req(7'h20, 1, 4'h0, 1'b1);
    check("patch_non_al_word", bus.out_data, 32'h00400000);
    wait_idle(20);

    // ROM index wraps mod 128.
    send_req(7'h7F, 2, 4'h0, 1'b0);
    check("rom_wrap_addr0", 32'(rom_addr), 32'h7F);
    tick();
    check("rom_wrap_addr1", 32'(rom_addr), 32'h00);
    wait_idle(20);

    // Unmapped word.
    send_req(7'h43, 1, 4'h0, 1'b0);
    check("unmapped_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("unmapped_err", 32'(err), 32'(exp_err));
    check("unmapped_idle", 32'(busy), 32'd0);
    tick();
    check("unmapped_no_done", 32'(done_cnt), 32'(exp_done));
    do_flush();
    check("flush_clears_err", 32'(err), 32'd0);

    // Zero-length request.
    send_req(7'h03, 2, 4'h0, 1'b0);
    wait_idle(20);
    send_req(7'h05, 0, 4'h0, 1'b0);
    check("len0_no_busy", 32'(busy), 32'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_ptr_kept", 32'(bus.out_addr), 32'(mptr));
    tick();
    tick();
    check("len0_done_count", 32'(done_cnt), 32'(exp_done));

    // Flush on the second word of a len=5 request with a new request pending.
    send_req(7'h10, 5, 4'h0, 1'b0);
    tick();
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_base = 7'h03;
    bus.req_len = LEN_W'(2);
    exp_q.delete();
    mptr = '0;
    exp_err = 1'b0;
    #1;
    check("flush_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    check("flush_out_addr", 32'(bus.out_addr), 32'd0);
    tick();
    tick();
    check("flush_not_accepted", 32'(busy), 32'd0);
    check("flush_no_done", 32'(done_cnt), 32'(exp_done));

    // Reset mid-sequence.
    send_req(7'h10, 5, 4'h0, 1'b0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    mptr = '0;
    exp_err = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    check("midrst_out_addr", 32'(bus.out_addr), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("midrst_no_done", 32'(done_cnt), 32'(exp_done));

    // Code-pointer wrap: 1025 single-word requests.
    for (int i = 0; i < 1025; i++) begin
      send_req(7'h05, 1, 4'h0, 1'b0);
      if (i == 1024) check("ptr_wrap_addr", 32'(bus.out_addr), 32'd0);
      while (busy) tick();
    end
    wait_idle(20);
    check("final_done_count", 32'(done_cnt), 32'(exp_done));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
